// File: rtl/lector_memoria_ventana_pkg.sv
// Shared constants for the windowed memory reader: FSM encodings and default sizing.
package lector_memoria_ventana_pkg;

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] LEYENDO  = 2'd1;
    localparam logic [1:0] DRENANDO = 2'd2;
    localparam logic [1:0] FIN      = 2'd3;

    localparam int unsigned PALABRAS_POR_BUFFER_DEF = 128;
    localparam int unsigned MAX_PENDIENTES_DEF      = 4;

endpackage

// File: rtl/lector_memoria_ventana_ffd.sv
// Enabled D register with asynchronous active-low clear, used to hold captured configuration.
module FlipFlopD_Habilitado #(
    parameter int unsigned ANCHO = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_habilitado,
    input  logic [ANCHO-1:0] i_d,
    output logic [ANCHO-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_q <= '0;
        end else if (i_habilitado) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/lector_memoria_ventana.sv
// Streams a contiguous block of memory words into a rotating set of internal buffers,
// keeping at most MAX_PENDIENTES reads outstanding.
module lector_memoria_ventana
    import lector_memoria_ventana_pkg::*;
#(
    parameter int unsigned BITS_BUS_DATOS_INSTR = 21,
    parameter int unsigned BITS_BUFFERS         = 3,
    parameter int unsigned BITS_DATOS_MEM       = 32,
    parameter int unsigned PALABRAS_POR_BUFFER  = PALABRAS_POR_BUFFER_DEF,
    parameter int unsigned MAX_PENDIENTES       = MAX_PENDIENTES_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            inicio,
    input  logic [BITS_BUS_DATOS_INSTR-1:0] direccion_mem_inicio_imagen,
    input  logic [BITS_BUS_DATOS_INSTR-1:0] cantidad_lecturas_mem,
    input  logic [BITS_BUFFERS-1:0]         cantidad_buffers_internos,
    output logic [BITS_BUS_DATOS_INSTR-1:0] mem_direccion,
    output logic                            mem_solicitud,
    input  logic                            mem_aceptada,
    input  logic                            mem_dato_valido,
    input  logic [BITS_DATOS_MEM-1:0]       mem_dato,
    output logic [BITS_DATOS_MEM-1:0]       buffer_dato,
    output logic                            buffer_escritura,
    output logic [BITS_BUFFERS-1:0]         buffer_seleccion,
    output logic                            ocupado,
    output logic                            terminado
);

    localparam int unsigned BITS_PALABRAS =
        (PALABRAS_POR_BUFFER > 1) ? $clog2(PALABRAS_POR_BUFFER) : 1;
    localparam logic [BITS_PALABRAS-1:0] ULTIMA_PALABRA = BITS_PALABRAS'(PALABRAS_POR_BUFFER - 1);
    localparam logic [BITS_BUS_DATOS_INSTR-1:0] LIMITE_PENDIENTES =
        BITS_BUS_DATOS_INSTR'(MAX_PENDIENTES);

    logic [1:0]                      r_estado;
    logic [1:0]                      w_estado_sig;
    logic [BITS_BUS_DATOS_INSTR-1:0] r_emitidas;
    logic [BITS_BUS_DATOS_INSTR-1:0] r_recibidas;
    logic [BITS_PALABRAS-1:0]        r_palabras;
    logic [BITS_BUFFERS-1:0]         r_sel;
    logic [BITS_DATOS_MEM-1:0]       r_buffer_dato;
    logic                            r_buffer_escritura;
    logic [BITS_BUFFERS-1:0]         r_buffer_seleccion;

    logic [BITS_BUS_DATOS_INSTR-1:0] w_base;
    logic [BITS_BUS_DATOS_INSTR-1:0] w_cantidad;
    logic [BITS_BUFFERS-1:0]         w_buffers;
    logic [BITS_BUFFERS-1:0]         w_ultimo_buffer;
    logic [BITS_BUS_DATOS_INSTR-1:0] w_pendientes;
    logic                            w_captura;
    logic                            w_activo;
    logic                            w_aceptada;
    logic                            w_beat;

    assign w_captura = inicio && (r_estado == REPOSO);

    FlipFlopD_Habilitado #(.ANCHO(BITS_BUS_DATOS_INSTR)) u_ff_base (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_habilitado (w_captura),
        .i_d          (direccion_mem_inicio_imagen),
        .o_q          (w_base)
    );

    FlipFlopD_Habilitado #(.ANCHO(BITS_BUS_DATOS_INSTR)) u_ff_cantidad (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_habilitado (w_captura),
        .i_d          (cantidad_lecturas_mem),
        .o_q          (w_cantidad)
    );

    FlipFlopD_Habilitado #(.ANCHO(BITS_BUFFERS)) u_ff_buffers (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_habilitado (w_captura),
        .i_d          (cantidad_buffers_internos),
        .o_q          (w_buffers)
    );

    // A buffer count of zero behaves as a single buffer.
    assign w_ultimo_buffer = (w_buffers == '0) ? '0 : w_buffers - BITS_BUFFERS'(1);

    assign w_pendientes  = r_emitidas - r_recibidas;
    assign w_activo      = (r_estado == LEYENDO) || (r_estado == DRENANDO);
    assign mem_solicitud = (r_estado == LEYENDO) && (r_emitidas < w_cantidad)
                           && (w_pendientes < LIMITE_PENDIENTES);
    assign w_aceptada    = mem_solicitud && mem_aceptada;
    assign w_beat        = mem_dato_valido && w_activo && (r_recibidas < w_cantidad);

    // Address is derived from the issued count, so it wraps naturally and cannot move during a stall.
    assign mem_direccion    = w_base + r_emitidas;
    assign buffer_dato      = r_buffer_dato;
    assign buffer_escritura = r_buffer_escritura;
    assign buffer_seleccion = r_buffer_seleccion;
    assign ocupado          = w_activo;
    assign terminado        = (r_estado == FIN);

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO: begin
                if (inicio) begin
                    w_estado_sig = (cantidad_lecturas_mem == '0) ? FIN : LEYENDO;
                end
            end
            LEYENDO: begin
                if (r_emitidas == w_cantidad) begin
                    w_estado_sig = DRENANDO;
                end
            end
            DRENANDO: begin
                if (r_recibidas == w_cantidad) begin
                    w_estado_sig = FIN;
                end
            end
            FIN:     w_estado_sig = REPOSO;
            default: w_estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado           <= REPOSO;
            r_emitidas         <= '0;
            r_recibidas        <= '0;
            r_palabras         <= '0;
            r_sel              <= '0;
            r_buffer_dato      <= '0;
            r_buffer_escritura <= 1'b0;
            r_buffer_seleccion <= '0;
        end else begin
            r_estado           <= w_estado_sig;
            r_buffer_escritura <= w_beat;
            if (w_beat) begin
                r_buffer_dato      <= mem_dato;
                r_buffer_seleccion <= r_sel;
            end
            if (w_captura) begin
                r_emitidas  <= '0;
                r_recibidas <= '0;
                r_palabras  <= '0;
                r_sel       <= '0;
            end else begin
                if (w_aceptada) begin
                    r_emitidas <= r_emitidas + BITS_BUS_DATOS_INSTR'(1);
                end
                if (w_beat) begin
                    r_recibidas <= r_recibidas + BITS_BUS_DATOS_INSTR'(1);
                    if (r_palabras == ULTIMA_PALABRA) begin
                        r_palabras <= '0;
                        r_sel      <= (r_sel == w_ultimo_buffer) ? '0
                                                                 : r_sel + BITS_BUFFERS'(1);
                    end else begin
                        r_palabras <= r_palabras + BITS_PALABRAS'(1);
                    end
                end
            end
        end
    end

endmodule
